ped_request_conditioner: RTL

//  Conditions the raw pedestrian push-button for the intersection controller.

---
 rtl/ped_request_conditioner_if.sv | 27 ++
 rtl/ped_request_conditioner.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/ped_request_conditioner_if.sv
// Pedestrian request conditioner signal bundle.
// The conditioner uses the slave modport: it receives the raw button and the
// intersection's pedestrian_green and drives request, wait_lamp and the
// debounced button level. The master modport is the environment side.
interface ped_request_conditioner_if;
   logic button_raw;    // raw asynchronous push-button, may bounce
   logic ped_green;     // pedestrian_green fed back from the intersection
   logic request;       // to intersection pedestrian_button
   logic wait_lamp;     // "request registered, please wait"
   logic button_clean;  // debounced, synchronised button level

   modport master (
      output button_raw,
      output ped_green,
      input  request,
      input  wait_lamp,
      input  button_clean
   );

   modport slave (
      input  button_raw,
      input  ped_green,
      output request,
      output wait_lamp,
      output button_clean
   );
endinterface

// File: rtl/ped_request_conditioner.sv
// Pedestrian push-button conditioner.
// Synchronises and debounces the raw button, turns each clean rising edge into
// a single latched request, and holds it until the intersection has shown the
// pedestrian green. Define PED_REQ_COOLDOWN_EN to build a post-service lockout
// (COOLDOWN state, counter and pending flag); without it, SERVING returns
// straight to IDLE when the green ends.
module ped_request_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DEBOUNCE_W      = 4,
   parameter int COOLDOWN_CYCLES = 16,
   parameter int COOLDOWN_W      = 5
) (
   input  logic                       clock,
   input  logic                       reset,   // asynchronous, active-low
   ped_request_conditioner_if.slave   ped
);

   // Elaboration-time sanity check: counters must be able to hold their limits.
   if ((DEBOUNCE_CYCLES < 1) || ((2 ** DEBOUNCE_W) <= DEBOUNCE_CYCLES) ||
       (COOLDOWN_CYCLES < 1) || ((2 ** COOLDOWN_W) <= COOLDOWN_CYCLES)) begin : g_param_check
      $error("ped_request_conditioner: counter width too small for its limit");
   end

   // The debounce counter fires on the cycle it would reach DEBOUNCE_CYCLES,
   // i.e. when it currently holds DEBOUNCE_CYCLES-1.
   localparam logic [DEBOUNCE_W-1:0] DB_LAST = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PENDING  = 2'd1,
      S_SERVING  = 2'd2
`ifdef PED_REQ_COOLDOWN_EN
      ,S_COOLDOWN = 2'd3
`endif
   } state_t;

   logic                  sync1_reg;
   logic                  sync2_reg;
   logic                  clean_reg;
   logic                  clean_d_reg;
   logic [DEBOUNCE_W-1:0] db_cnt_reg;
   logic                  press;

   state_t                state_reg;
   state_t                state_next;
   logic                  request_reg;
   logic                  request_next;
   logic                  wait_lamp_reg;
   logic                  wait_lamp_next;

   // Two-flop synchroniser for the asynchronous button input.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
      end else begin
         sync1_reg <= ped.button_raw;
         sync2_reg <= sync1_reg;
      end
   end

   // Debounce: clean level follows sync2 only after it has differed for
   // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         db_cnt_reg <= '0;
         clean_reg  <= 1'b0;
      end else if (sync2_reg == clean_reg) begin
         db_cnt_reg <= '0;
      end else if (db_cnt_reg == DB_LAST) begin
         db_cnt_reg <= '0;
         clean_reg  <= sync2_reg;
      end else begin
         db_cnt_reg <= db_cnt_reg + DEBOUNCE_W'(1);
      end
   end

   // Delayed clean level for rising-edge detection.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         clean_d_reg <= 1'b0;
      end else begin
         clean_d_reg <= clean_reg;
      end
   end

   // One-cycle pulse per debounced press; a held button yields only one.
   assign press = clean_reg & ~clean_d_reg;

`ifdef PED_REQ_COOLDOWN_EN
   localparam logic [COOLDOWN_W-1:0] COOL_LAST = COOLDOWN_W'(COOLDOWN_CYCLES - 1);

   logic [COOLDOWN_W-1:0] cool_cnt_reg;
   logic                  pending_reg;
   logic                  pending_next;
   logic                  cool_done;

   assign cool_done = (state_reg == S_COOLDOWN) && (cool_cnt_reg == COOL_LAST);

   // Lockout timer: runs 0..COOLDOWN_CYCLES-1 while in COOLDOWN, idles at 0.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cool_cnt_reg <= '0;
      end else if ((state_reg == S_COOLDOWN) && !cool_done) begin
         cool_cnt_reg <= cool_cnt_reg + COOLDOWN_W'(1);
      end else begin
         cool_cnt_reg <= '0;
      end
   end

   // Remember a press made during the lockout; consumed at expiry.
   always_comb begin
      pending_next = pending_reg;
      if (state_reg == S_COOLDOWN) begin
         if (cool_done) begin
            pending_next = 1'b0;
         end else if (press) begin
            pending_next = 1'b1;
         end
      end
   end

   // Pending flag register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_reg <= 1'b0;
      end else begin
         pending_reg <= pending_next;
      end
   end
`endif

   // FSM state and registered outputs (decoded from the next state).
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg     <= S_IDLE;
         request_reg   <= 1'b0;
         wait_lamp_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         request_reg   <= request_next;
         wait_lamp_reg <= wait_lamp_next;
      end
   end

   // Next-state logic; presses outside IDLE (and COOLDOWN) are dropped.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (press) begin
               state_next = S_PENDING;
            end
         end
         S_PENDING: begin
            if (ped.ped_green) begin
               state_next = S_SERVING;
            end
         end
         S_SERVING: begin
            if (!ped.ped_green) begin
`ifdef PED_REQ_COOLDOWN_EN
               state_next = S_COOLDOWN;
`else
               state_next = S_IDLE;
`endif
            end
         end
`ifdef PED_REQ_COOLDOWN_EN
         S_COOLDOWN: begin
            if (cool_done) begin
               state_next = (pending_reg || press) ? S_PENDING : S_IDLE;
            end
         end
`endif
         default: state_next = S_IDLE;
      endcase
   end

   // Output decode from the next state so outputs align with the state.
   always_comb begin
      request_next   = (state_next == S_PENDING);
      wait_lamp_next = (state_next == S_PENDING);
`ifdef PED_REQ_COOLDOWN_EN
      if (state_next == S_COOLDOWN) begin
         wait_lamp_next = pending_next;
      end
`endif
   end

   assign ped.request      = request_reg;
   assign ped.wait_lamp    = wait_lamp_reg;
   assign ped.button_clean = clean_reg;

endmodule
